// File: rtl/gpio_key_debounce.sv
// Eight-channel active-low key input block: 2-flop synchroniser, per-channel
// debounce FSM with counter, registered press/release pulses and key encoder.
module gpio_key_debounce #(
  parameter int unsigned N_KEYS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned CNT_W           = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              key_valid,
  output logic [2:0]        key_code
);

  localparam int unsigned     CODE_W   = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_UP   = 2'd0,
    WAIT_DOWN = 2'd1,
    IDLE_DOWN = 2'd2,
    WAIT_UP   = 2'd3
  } state_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] s;

  state_t           state    [N_KEYS];
  state_t           state_nx [N_KEYS];
  logic [CNT_W-1:0] cnt      [N_KEYS];
  logic [CNT_W-1:0] cnt_nx   [N_KEYS];

  logic [N_KEYS-1:0] level_nx;
  logic [N_KEYS-1:0] press_nx;
  logic [N_KEYS-1:0] release_nx;
  logic [CODE_W-1:0] code_nx;

  // Two-flop synchroniser; pins idle high so the chain resets to "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  // Per-channel state, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N_KEYS); k++) begin
        state[k] <= IDLE_UP;
        cnt[k]   <= '0;
      end
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      for (int k = 0; k < int'(N_KEYS); k++) begin
        state[k] <= state_nx[k];
        cnt[k]   <= cnt_nx[k];
      end
      key_level   <= level_nx;
      key_press   <= press_nx;
      key_release <= release_nx;
    end
  end

  // Debounce decisions: a level change is accepted only after the sampled
  // input has disagreed with it for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    level_nx   = key_level;
    press_nx   = '0;
    release_nx = '0;
    for (int k = 0; k < int'(N_KEYS); k++) begin
      state_nx[k] = state[k];
      cnt_nx[k]   = cnt[k];
      case (state[k])
        IDLE_UP: begin
          if (s[k]) begin
            state_nx[k] = WAIT_DOWN;
            cnt_nx[k]   = CNT_W'(1);
          end
        end
        WAIT_DOWN: begin
          if (!s[k]) begin
            state_nx[k] = IDLE_UP;
            cnt_nx[k]   = '0;
          end else if (cnt[k] == CNT_LAST) begin
            state_nx[k] = IDLE_DOWN;
            cnt_nx[k]   = '0;
            level_nx[k] = 1'b1;
            press_nx[k] = 1'b1;
          end else begin
            cnt_nx[k] = cnt[k] + CNT_W'(1);
          end
        end
        IDLE_DOWN: begin
          if (!s[k]) begin
            state_nx[k] = WAIT_UP;
            cnt_nx[k]   = CNT_W'(1);
          end
        end
        WAIT_UP: begin
          if (s[k]) begin
            state_nx[k] = IDLE_DOWN;
            cnt_nx[k]   = '0;
          end else if (cnt[k] == CNT_LAST) begin
            state_nx[k]   = IDLE_UP;
            cnt_nx[k]     = '0;
            level_nx[k]   = 1'b0;
            release_nx[k] = 1'b1;
          end else begin
            cnt_nx[k] = cnt[k] + CNT_W'(1);
          end
        end
        default: begin
          state_nx[k] = IDLE_UP;
          cnt_nx[k]   = '0;
        end
      endcase
    end
  end

  // Priority encoder: the lowest pressed channel wins, otherwise hold.
  always_comb begin
    code_nx = key_code;
    for (int k = int'(N_KEYS) - 1; k >= 0; k--) begin
      if (key_press[k]) code_nx = CODE_W'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= |key_press;
      key_code  <= code_nx;
    end
  end

endmodule

// File: tb/tb_gpio_key_debounce.sv
// Directed bench for gpio_key_debounce with a short debounce window and a
// run-length reference model checked every cycle.
module tb_gpio_key_debounce;

  localparam int unsigned N = 8;
  localparam int unsigned D = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] key_n;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic         key_valid;
  logic [2:0]   key_code;

  int tests = 0;
  int fails = 0;
  bit en = 0;

  gpio_key_debounce #(
    .N_KEYS(N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_valid(key_valid),
    .key_code(key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [N-1:0] v, input logic [2:0] hold);
    logic [2:0] r;
    r = hold;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // Reference: raw pins reach the debouncer two edges late; a level flips once
  // the delayed pin has disagreed with it for D edges in a row.
  logic [N-1:0] m_p1, m_p2, m_s, m_level, m_press, m_rel;
  logic         m_valid;
  logic [2:0]   m_code;
  int           run [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 = '1; m_p2 = '1; m_level = '0; m_press = '0; m_rel = '0;
      m_valid = 1'b0; m_code = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      m_s     = ~m_p2;
      m_valid = |m_press;
      m_code  = lowest(m_press, m_code);
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < N; i++) begin
        if (m_s[i] != m_level[i]) begin
          run[i]++;
          if (run[i] == D) begin
            m_level[i] = m_s[i];
            if (m_s[i]) m_press[i] = 1'b1;
            else        m_rel[i]   = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_p2 = m_p1;
      m_p1 = key_n;
    end
  end

  int press_cnt [N];
  int rel_cnt   [N];
  int valid_cnt;

  initial begin
    for (int i = 0; i < N; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end
    valid_cnt = 0;
  end

  always @(negedge clk) begin
    if (en) begin
      check("level", key_level, m_level);
      check("press", key_press, m_press);
      check("release", key_release, m_rel);
      check("valid", key_valid, m_valid);
      check("code", key_code, m_code);
      check("press_and_release", key_press & key_release, '0);
      for (int i = 0; i < N; i++) begin
        press_cnt[i] += int'(key_press[i]);
        rel_cnt[i]   += int'(key_release[i]);
      end
      valid_cnt += int'(key_valid);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int p0, r0, v0;

  initial begin
    key_n = '1;
    rst_n = 1'b0;
    settle(3);
    check("rst_level", key_level, '0);
    check("rst_press", key_press, '0);
    check("rst_valid", key_valid, '0);
    check("rst_code", key_code, '0);
    rst_n = 1'b1;
    en = 1'b1;
    settle(2);

    // Clean press on channel 0
    key_n[0] = 1'b0;
    edges(5);
    check("t1_level_before", key_level[0], 1'b0);
    edges(1);
    check("t1_level", key_level[0], 1'b1);
    check("t1_press", key_press[0], 1'b1);
    edges(1);
    check("t1_press_gone", key_press[0], 1'b0);
    check("t1_valid", key_valid, 1'b1);
    check("t1_code", key_code, 3'd0);
    @(negedge clk);
    key_n[0] = 1'b1;
    settle(12);
    check("t1_released", key_level[0], 1'b0);

    // Bounce on channel 3, toggling every two cycles
    p0 = press_cnt[3]; r0 = rel_cnt[3]; v0 = valid_cnt;
    for (int t = 0; t < 10; t++) begin
      key_n[3] = ~key_n[3];
      settle(2);
    end
    key_n[3] = 1'b1;
    settle(10);
    check("t2_level", key_level[3], 1'b0);
    check("t2_presses", press_cnt[3] - p0, 0);
    check("t2_releases", rel_cnt[3] - r0, 0);
    check("t2_valids", valid_cnt - v0, 0);

    // Bounce then settle on channel 5
    p0 = press_cnt[5]; r0 = rel_cnt[5];
    key_n[5] = 1'b0; settle(1);
    key_n[5] = 1'b1; settle(1);
    key_n[5] = 1'b0; settle(2);
    key_n[5] = 1'b1; settle(1);
    key_n[5] = 1'b0; settle(3);
    key_n[5] = 1'b1; settle(1);
    key_n[5] = 1'b0;
    edges(5);
    check("t3_no_press_yet", press_cnt[5] - p0, 0);
    check("t3_press_early", key_press[5], 1'b0);
    edges(1);
    check("t3_press", key_press[5], 1'b1);
    @(negedge clk);
    settle(50);
    key_n[5] = 1'b1;
    settle(10);
    check("t3_presses", press_cnt[5] - p0, 1);
    check("t3_releases", rel_cnt[5] - r0, 1);
    check("t3_level", key_level[5], 1'b0);

    // Simultaneous press on channels 3 and 5
    key_n = 8'hD7;
    edges(6);
    check("t4_press", key_press, 8'h28);
    check("t4_level", key_level, 8'h28);
    edges(1);
    check("t4_valid", key_valid, 1'b1);
    check("t4_code", key_code, 3'd3);
    edges(10);
    check("t4_code_held", key_code, 3'd3);
    check("t4_valid_low", key_valid, 1'b0);
    @(negedge clk);
    key_n = '1;
    settle(10);

    // Reset during WAIT_DOWN with channels 6 (down) and 2 (waiting) held
    key_n[6] = 1'b0;
    settle(8);
    check("t5_ch6_down", key_level[6], 1'b1);
    key_n[2] = 1'b0;
    edges(3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_level", key_level, '0);
    check("t5_rst_press", key_press, '0);
    check("t5_rst_release", key_release, '0);
    check("t5_rst_valid", key_valid, 1'b0);
    check("t5_rst_code", key_code, 3'd0);
    settle(3);
    rst_n = 1'b1;
    edges(5);
    check("t5_press_early", key_press[2], 1'b0);
    edges(1);
    check("t5_press", key_press[2], 1'b1);
    check("t5_level", key_level, 8'h44);
    edges(1);
    check("t5_code", key_code, 3'd2);
    @(negedge clk);
    key_n = '1;
    settle(10);
    check("t5_all_up", key_level, '0);

    en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
